// File: rtl/alu_muldiv_if.sv
// Bus between the control unit and the alu_muldiv execution unit.
//   master: drives start/op/a/b, observes results and status.
//   slave : the execution unit.
//   start, op, a, b             - operation request
//   y, zero, overflow           - single-cycle and MUL/DIV result (y = lo after MUL/DIV)
//   div_by_zero, hi, lo         - multiply/divide results
//   busy, done                  - engine iterating / one-cycle result pulse
interface alu_muldiv_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             overflow;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  y, zero, overflow, div_by_zero, hi, lo, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output y, zero, overflow, div_by_zero, hi, lo, busy, done
  );
endinterface

// File: rtl/alu_muldiv.sv
// Registered execution unit: single-cycle logic/arith/compare/shift ops plus an
// iterative shift-add multiplier and restoring divider writing HI/LO.
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - alu_muldiv_if slave port (request, results, busy/done status)
module alu_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  alu_muldiv_if.slave  bus
);

  localparam int unsigned SW = $clog2(WIDTH);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpNor  = 4'b0100;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpXor  = 4'b1100;
  localparam logic [3:0] OpSltu = 4'b1101;
  localparam logic [3:0] OpSll  = 4'b1110;
  localparam logic [3:0] OpSrl  = 4'b1111;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] y_q, hi_q, lo_q;
  logic             zero_q, ovf_q, dbz_q, done_q;
  // acc_q: partial product high half / partial remainder.
  // quo_q: multiplier being consumed LSB-first / dividend shifting out MSB-first.
  logic [WIDTH-1:0] acc_q, quo_q, mag_b_q;
  logic             neg_res_q, neg_rem_q, b_zero_q;
  logic [SW-1:0]    cnt_q;

  // Single-cycle datapath
  logic [WIDTH-1:0] b_neg, sum_add, sum_sub, alu_y;
  logic [SW-1:0]    shamt;
  logic             alu_ovf;

  always_comb begin
    b_neg   = ~bus.b + WIDTH'(1);
    sum_add = bus.a + bus.b;
    sum_sub = bus.a + b_neg;
    shamt   = bus.b[SW-1:0];
    alu_y   = '0;
    alu_ovf = 1'b0;
    case (bus.op)
      OpAnd:  alu_y = bus.a & bus.b;
      OpOr:   alu_y = bus.a | bus.b;
      OpAdd: begin
        alu_y   = sum_add;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_add[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpSub: begin
        alu_y   = sum_sub;
        alu_ovf = (bus.a[WIDTH-1] == b_neg[WIDTH-1]) && (sum_sub[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpNor:  alu_y = ~(bus.a | bus.b);
      OpSlt:  alu_y = {{(WIDTH-1){1'b0}}, $signed(bus.a) < $signed(bus.b)};
      OpXor:  alu_y = bus.a ^ bus.b;
      OpSltu: alu_y = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
      OpSll:  alu_y = bus.a << shamt;
      OpSrl:  alu_y = bus.a >> shamt;
      default: ;
    endcase
  end

  // Operand preparation for MUL/DIV: even op[0] selects the signed variant.
  logic             is_mul, is_div, op_signed, sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    is_mul    = (bus.op[3:1] == 3'b100);
    is_div    = (bus.op[3:1] == 3'b101);
    op_signed = ~bus.op[0];
    sign_a    = op_signed & bus.a[WIDTH-1];
    sign_b    = op_signed & bus.b[WIDTH-1];
    mag_a     = sign_a ? (~bus.a + WIDTH'(1)) : bus.a;
    mag_b     = sign_b ? (~bus.b + WIDTH'(1)) : bus.b;
  end

  // One iteration of each engine, plus the sign fix-up applied on the last one.
  logic [WIDTH-1:0]   mul_add, mul_acc_nx, mul_quo_nx;
  logic [WIDTH:0]     mul_sum, div_shift, div_sub;
  logic               div_ge, last;
  logic [WIDTH-1:0]   div_acc_nx, div_quo_nx, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;

  always_comb begin
    mul_add    = quo_q[0] ? mag_b_q : '0;
    mul_sum    = {1'b0, acc_q} + {1'b0, mul_add};
    mul_acc_nx = mul_sum[WIDTH:1];
    mul_quo_nx = {mul_sum[0], quo_q[WIDTH-1:1]};
    prod       = {mul_acc_nx, mul_quo_nx};
    prod_fix   = neg_res_q ? -prod : prod;

    // Partial remainder stays below the divisor, so the difference fits WIDTH bits.
    div_shift  = {acc_q, quo_q[WIDTH-1]};
    div_ge     = div_shift >= {1'b0, mag_b_q};
    div_sub    = div_shift - {1'b0, mag_b_q};
    div_acc_nx = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_quo_nx = {quo_q[WIDTH-2:0], div_ge};
    // With b == 0 every step subtracts nothing, so the remainder rebuilds |a|;
    // re-applying the dividend sign yields hi = a. Only the quotient is forced.
    quo_fix    = b_zero_q ? '1 : (neg_res_q ? -div_quo_nx : div_quo_nx);
    rem_fix    = neg_rem_q ? -div_acc_nx : div_acc_nx;

    last       = (cnt_q == {SW{1'b1}});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      y_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      zero_q    <= 1'b1;
      ovf_q     <= 1'b0;
      dbz_q     <= 1'b0;
      done_q    <= 1'b0;
      acc_q     <= '0;
      quo_q     <= '0;
      mag_b_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (is_mul || is_div) begin
              acc_q     <= '0;
              quo_q     <= mag_a;
              mag_b_q   <= mag_b;
              neg_res_q <= sign_a ^ sign_b;
              neg_rem_q <= sign_a;
              b_zero_q  <= (bus.b == '0);
              cnt_q     <= '0;
              state_q   <= is_mul ? StMul : StDiv;
            end else begin
              y_q    <= alu_y;
              zero_q <= (alu_y == '0);
              ovf_q  <= alu_ovf;
              done_q <= 1'b1;
            end
          end
        end
        StMul: begin
          acc_q <= mul_acc_nx;
          quo_q <= mul_quo_nx;
          cnt_q <= cnt_q + SW'(1);
          if (last) begin
            hi_q    <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q    <= prod_fix[WIDTH-1:0];
            y_q     <= prod_fix[WIDTH-1:0];
            zero_q  <= (prod_fix[WIDTH-1:0] == '0);
            ovf_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        StDiv: begin
          acc_q <= div_acc_nx;
          quo_q <= div_quo_nx;
          cnt_q <= cnt_q + SW'(1);
          if (last) begin
            hi_q    <= rem_fix;
            lo_q    <= quo_fix;
            y_q     <= quo_fix;
            zero_q  <= (quo_fix == '0);
            ovf_q   <= 1'b0;
            dbz_q   <= b_zero_q;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.y           = y_q;
  assign bus.zero        = zero_q;
  assign bus.overflow    = ovf_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv (WIDTH=32 main instance, WIDTH=8 side instance).
module tb_alu_muldiv;

  logic clk;
  logic reset;
  int   cyc;
  int   n_tests;
  int   n_fail;

  alu_muldiv_if #(.WIDTH(32)) bus ();
  alu_muldiv_if #(.WIDTH(8))  bus8 ();

  alu_muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  alu_muldiv #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    logic        ovf;
    logic        dbz;
    logic        md;
    int          issue;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_dbz;

  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    longint          sa, sb, sp, q, r;
    longint unsigned ua, ub, up;
    logic [31:0]     bp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.md  = 1'b0;
    e.ovf = 1'b0;
    e.y   = '0;
    case (op)
      4'b0000: e.y = a & b;
      4'b0001: e.y = a | b;
      4'b0010, 4'b0110: begin
        bp    = (op == 4'b0110) ? (32'd0 - b) : b;
        sp    = sa + longint'($signed(bp));
        e.y   = sp[31:0];
        e.ovf = (sp > SMax) || (sp < SMin);
      end
      4'b0100: e.y = ~(a | b);
      4'b0111: e.y = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: e.y = a ^ b;
      4'b1101: e.y = (ua < ub) ? 32'd1 : 32'd0;
      4'b1110: begin up = ua << b[4:0]; e.y = up[31:0]; end
      4'b1111: e.y = a >> b[4:0];
      4'b1000: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; e.md = 1'b1; end
      4'b1001: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; e.md = 1'b1; end
      4'b1010, 4'b1011: begin
        e.md = 1'b1;
        if (b == 32'd0) begin
          m_lo  = 32'hFFFF_FFFF;
          m_hi  = a;
          m_dbz = 1'b1;
        end else begin
          if (op == 4'b1010) begin
            q = sa / sb;
            r = sa % sb;
          end else begin
            q = longint'(ua / ub);
            r = longint'(ua % ub);
          end
          m_lo  = q[31:0];
          m_hi  = r[31:0];
          m_dbz = 1'b0;
        end
      end
      default: e.y = '0;
    endcase
    if (e.md) e.y = m_lo;
    e.zero = (e.y == 32'd0);
    e.hi   = m_hi;
    e.lo   = m_lo;
    e.dbz  = m_dbz;
  endtask

  // Called at posedge+1; waits for the engine to be free, then presents start for one edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   guard;
    guard = 0;
    while (bus.busy && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (bus.busy) check("issue_wait_busy", 64'(bus.busy), 64'd0);
    model(op, a, b, e);
    e.issue = cyc + 1;
    sb_q.push_back(e);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: pops one expectation per done pulse.
  initial begin : monitor
    exp_t e;
    int   busy_run;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_run = 0;
      end else begin
        if (bus.busy) busy_run++;
        if (bus.done) begin
          if (sb_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("y",           64'(bus.y),           64'(e.y));
            check("zero",        64'(bus.zero),        64'(e.zero));
            check("overflow",    64'(bus.overflow),    64'(e.ovf));
            check("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
            check("hi",          64'(bus.hi),          64'(e.hi));
            check("lo",          64'(bus.lo),          64'(e.lo));
            check("latency",     64'(cyc - e.issue),   e.md ? 64'd32 : 64'd0);
            check("busy_cycles", 64'(busy_run),        e.md ? 64'd32 : 64'd0);
          end
          busy_run = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int n8;
    int got8;
    int guard;
    n_tests   = 0;
    n_fail    = 0;
    m_hi      = '0;
    m_lo      = '0;
    m_dbz     = 1'b0;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus8.start = 1'b0;
    bus8.op    = '0;
    bus8.a     = '0;
    bus8.b     = '0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_y",    64'(bus.y),           64'd0);
    check("rst_zero", 64'(bus.zero),        64'd1);
    check("rst_ovf",  64'(bus.overflow),    64'd0);
    check("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    check("rst_hi",   64'(bus.hi),          64'd0);
    check("rst_lo",   64'(bus.lo),          64'd0);
    check("rst_busy", 64'(bus.busy),        64'd0);
    check("rst_done", 64'(bus.done),        64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed single-cycle sweep
    issue(4'b0010, 32'h7FFF_FFFF, 32'd1);
    issue(4'b0110, 32'h7FFF_FFFF, 32'd1);
    issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
    issue(4'b1101, 32'hFFFF_FFFF, 32'd1);
    issue(4'b0110, 32'd5, 32'd5);

    // MULT -3*7 with a start pulse while busy that must be ignored
    issue(4'b1000, 32'hFFFF_FFFD, 32'd7);
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.op    = 4'b0010;
    bus.a     = 32'd1000;
    bus.b     = 32'd2000;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    issue(4'b0010, 32'd10, 32'd20);

    issue(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'b1010, 32'hFFFF_FFF9, 32'd2);
    issue(4'b1011, 32'd100, 32'd0);
    issue(4'b1011, 32'd9, 32'd3);
    issue(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'b1010, 32'hFFFF_FFF9, 32'd0);
    issue(4'b0011, 32'd12, 32'd34);

    // Reset in the middle of a MULT
    issue(4'b1000, 32'd123, 32'd456);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_hi",   64'(bus.hi),   64'd0);
    check("midrst_lo",   64'(bus.lo),   64'd0);
    check("midrst_y",    64'(bus.y),    64'd0);
    check("midrst_zero", 64'(bus.zero), 64'd1);
    sb_q.delete();
    m_hi  = '0;
    m_lo  = '0;
    m_dbz = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue(4'b0010, 32'd3, 32'd4);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), pick(), pick());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    // WIDTH=8 instance
    bus8.op    = 4'b1001;
    bus8.a     = 8'hFF;
    bus8.b     = 8'hFF;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    n8   = 0;
    got8 = 0;
    for (int i = 0; i < 20 && got8 == 0; i++) begin
      if (bus8.done) begin
        got8 = 1;
      end else begin
        if (bus8.busy) n8++;
        @(posedge clk);
        #1;
      end
    end
    check("w8_done", 64'(got8),    64'd1);
    check("w8_busy", 64'(n8),      64'd8);
    check("w8_hi",   64'(bus8.hi), 64'hFE);
    check("w8_lo",   64'(bus8.lo), 64'h01);
    bus8.op    = 4'b1110;
    bus8.a     = 8'h01;
    bus8.b     = 8'd9;
    bus8.start = 1'b1;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    check("w8_sll_done", 64'(bus8.done), 64'd1);
    check("w8_sll_y",    64'(bus8.y),    64'h02);

    guard = 0;
    while (sb_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
